// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared constants, state encoding and helpers for tx_arbiter
package uart_pkg;

    localparam int DATA_WIDTH    = 8;
    localparam int NUM_REQ_DEF   = 4;
    localparam int MAX_BURST_DEF = 16;
    localparam int BURST_W       = 8;

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_t;

    // Width of an index able to address n requesters (at least one bit)
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tx_arbiter_if.sv
// rtl/tx_arbiter_if.sv - requester, FIFO and status signals of tx_arbiter
interface tx_arbiter_if #(
    parameter int NUM_REQ    = uart_pkg::NUM_REQ_DEF,
    parameter int DATA_WIDTH = uart_pkg::DATA_WIDTH
);
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_last;
    logic [NUM_REQ-1:0]            req_ready;
    logic [DATA_WIDTH-1:0]         fifo_data;
    logic                          fifo_wr_en;
    logic                          fifo_full;
    logic [NUM_REQ-1:0]            grant;
    logic                          busy;
    logic                          pkt_done;

    // Environment side: requesters and the transmitter FIFO
    modport master (
        output req_valid, req_data, req_last, fifo_full,
        input  req_ready, fifo_data, fifo_wr_en, grant, busy, pkt_done
    );

    // Arbiter side
    modport slave (
        input  req_valid, req_data, req_last, fifo_full,
        output req_ready, fifo_data, fifo_wr_en, grant, busy, pkt_done
    );
endinterface

// File: rtl/rr_picker.sv
// rtl/rr_picker.sv - combinational round-robin search starting after last_owner
module rr_picker #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_owner,
    output logic [NUM_REQ-1:0] pick,
    output logic [IDX_W-1:0]   pick_idx,
    output logic               any_valid
);

    // Walk the requesters from last_owner+1 wrapping around; first hit wins
    always_comb begin
        logic             found;
        int               cand_i;
        logic [IDX_W-1:0] cand;
        pick      = '0;
        pick_idx  = '0;
        any_valid = |req;
        found     = 1'b0;
        cand_i    = 0;
        cand      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand_i = (int'(last_owner) + 1 + k) % NUM_REQ;
            cand   = cand_i[IDX_W-1:0];
            if (!found && req[cand]) begin
                found       = 1'b1;
                pick[cand]  = 1'b1;
                pick_idx    = cand;
            end
        end
    end

endmodule

// File: rtl/tx_arbiter.sv
// rtl/tx_arbiter.sv - round-robin byte arbiter feeding a transmitter FIFO
module tx_arbiter #(
    parameter int NUM_REQ    = uart_pkg::NUM_REQ_DEF,
    parameter int DATA_WIDTH = uart_pkg::DATA_WIDTH,
    parameter int MAX_BURST  = uart_pkg::MAX_BURST_DEF
) (
    input  logic         CLK,
    input  logic         RST,
    tx_arbiter_if.slave  bus
);
    import uart_pkg::*;

    localparam int                IDX_W       = idx_width(NUM_REQ);
    localparam logic [BURST_W-1:0] MAX_BURST_B = BURST_W'(MAX_BURST);

    state_t               state_q, state_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic [IDX_W-1:0]     owner_q, owner_d;
    logic [IDX_W-1:0]     last_owner_q, last_owner_d;
    logic [BURST_W-1:0]   burst_q, burst_d;
    logic [BURST_W-1:0]   burst_inc;

    logic [NUM_REQ-1:0]   pick;
    logic [IDX_W-1:0]     pick_idx;
    logic                 any_valid;

    logic [NUM_REQ-1:0]   ready_vec;
    logic                 xfer;
    logic                 cur_last;
    logic [DATA_WIDTH-1:0] data_sel;
    logic                 done_pulse;
    logic                 busy_o;

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_picker (
        .req        (bus.req_valid),
        .last_owner (last_owner_q),
        .pick       (pick),
        .pick_idx   (pick_idx),
        .any_valid  (any_valid)
    );

    // State register; reset leaves requester 0 as the next in line
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            owner_q      <= '0;
            last_owner_q <= IDX_W'(NUM_REQ - 1);
            burst_q      <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            burst_q      <= burst_d;
        end
    end

    // Next state: grant in IDLE, release on packet end or burst limit
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        burst_d      = burst_q;
        burst_inc    = burst_q + BURST_W'(1);
        case (state_q)
            IDLE: begin
                if (any_valid) begin
                    state_d = XFER;
                    grant_d = pick;
                    owner_d = pick_idx;
                    burst_d = '0;
                end
            end
            XFER: begin
                if (xfer) begin
                    burst_d = burst_inc;
                    if (cur_last || (burst_inc == MAX_BURST_B)) begin
                        state_d      = IDLE;
                        grant_d      = '0;
                        last_owner_d = owner_q;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    // Outputs: zero-latency pass-through of the owner's byte, gated by full and reset
    always_comb begin
        ready_vec = '0;
        if (!RST && (state_q == XFER) && !bus.fifo_full) begin
            ready_vec = grant_q;
        end
        xfer       = |(bus.req_valid & ready_vec);
        cur_last   = bus.req_last[owner_q];
        data_sel   = bus.req_data[owner_q*DATA_WIDTH +: DATA_WIDTH];
        done_pulse = xfer & cur_last;
        busy_o     = |grant_q;
    end

    assign bus.req_ready  = ready_vec;
    assign bus.fifo_wr_en = xfer;
    assign bus.fifo_data  = data_sel;
    assign bus.pkt_done   = done_pulse;
    assign bus.grant      = grant_q;
    assign bus.busy       = busy_o;

endmodule

// File: tb/tb_tx_arbiter.sv
// tb/tb_tx_arbiter.sv - self-checking bench for tx_arbiter
module tb_tx_arbiter;

    localparam int NR = 4;
    localparam int DW = 8;
    localparam int MB = 16;

    typedef struct {
        int         idx;
        logic [7:0] data;
        logic       last;
    } ent_t;

    typedef struct {
        logic [NR-1:0] mask;
        logic [NR-1:0] exp_grant;
    } vec_t;

    logic CLK = 1'b0;
    logic RST = 1'b1;

    tx_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW)) bus ();

    tx_arbiter #(
        .NUM_REQ    (NR),
        .DATA_WIDTH (DW),
        .MAX_BURST  (MB)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus.slave)
    );

    ent_t          rq[$];
    ent_t          sb[$];
    logic [NR-1:0] hold;
    int            n_tests  = 0;
    int            n_fail   = 0;
    int            xfer_cnt = 0;
    vec_t          vecs[8];
    logic [NR-1:0] exp33[16];

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic offer(input int i, input logic [7:0] d, input logic l);
        rq.push_back('{i, d, l});
    endtask

    task automatic exp_byte(input int i, input logic [7:0] d, input logic l);
        sb.push_back('{i, d, l});
    endtask

    task automatic tick();
        @(negedge CLK);
        #1;
    endtask

    // Present each requester's head entry unless it is being held back
    task automatic drive_inputs();
        logic [NR-1:0]    v;
        logic [NR-1:0]    l;
        logic [NR-1:0]    taken;
        logic [NR*DW-1:0] d;
        v     = '0;
        l     = '0;
        taken = '0;
        d     = (NR*DW)'($urandom());
        foreach (rq[k]) begin
            if (!taken[rq[k].idx]) begin
                taken[rq[k].idx] = 1'b1;
                if (!hold[rq[k].idx]) begin
                    v[rq[k].idx]             = 1'b1;
                    l[rq[k].idx]             = rq[k].last;
                    d[rq[k].idx*DW +: DW]    = rq[k].data;
                end
            end
        end
        bus.req_valid = v;
        bus.req_last  = l;
        bus.req_data  = d;
    endtask

    task automatic consume(input int i);
        int found;
        found = -1;
        foreach (rq[k]) begin
            if (found < 0 && rq[k].idx == i) found = k;
        end
        if (found >= 0) rq.delete(found);
    endtask

    always @(posedge CLK) begin
        #2;
        drive_inputs();
    end

    // Scoreboard monitor: every write must match the next predicted byte
    always @(negedge CLK) begin
        ent_t e;
        if (!RST) begin
            chk("busy_vs_grant", 32'(bus.busy), 32'(|bus.grant));
            chk("grant_onehot0", 32'($onehot0(bus.grant)), 32'd1);
            chk("ready_only_owner", 32'(bus.req_ready & ~bus.grant), 32'd0);
            if (bus.fifo_wr_en) begin
                chk("wr_while_full", 32'(bus.fifo_full), 32'd0);
                chk("sb_has_entry", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("fifo_data", 32'(bus.fifo_data), 32'(e.data));
                    chk("pkt_done", 32'(bus.pkt_done), 32'(e.last));
                    chk("write_owner", 32'(bus.grant), 32'd1 << e.idx);
                end
                xfer_cnt++;
            end else begin
                chk("pkt_done_no_write", 32'(bus.pkt_done), 32'd0);
            end
            for (int i = 0; i < NR; i++) begin
                if (bus.req_valid[i] && bus.req_ready[i]) consume(i);
            end
        end
    end

    task automatic do_reset();
        @(posedge CLK);
        #1;
        RST           = 1'b1;
        bus.fifo_full = 1'b0;
        hold          = '0;
        rq.delete();
        sb.delete();
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b0;
    endtask

    task automatic wait_busy(input string name, input int budget, input logic [NR-1:0] exp_g);
        int c;
        c = 0;
        tick();
        while (!bus.busy && c < budget) begin
            tick();
            c++;
        end
        chk(name, 32'(bus.grant), 32'(exp_g));
    endtask

    task automatic wait_xfers(input string name, input int target, input int budget);
        int c;
        c = 0;
        do begin
            tick();
            c++;
        end while (xfer_cnt < target && c < budget);
        chk(name, xfer_cnt, target);
    endtask

    task automatic wait_drain(input string name, input int budget);
        int c;
        c = 0;
        while (!(sb.size() == 0 && !bus.busy) && c < budget) begin
            tick();
            c++;
        end
        chk(name, sb.size(), 0);
    endtask

    initial begin
        int base;
        vecs[0] = '{4'b0110, 4'b0010};
        vecs[1] = '{4'b1111, 4'b0100};
        vecs[2] = '{4'b0011, 4'b0001};
        vecs[3] = '{4'b0001, 4'b0001};
        vecs[4] = '{4'b1010, 4'b0010};
        vecs[5] = '{4'b1010, 4'b1000};
        vecs[6] = '{4'b1000, 4'b1000};
        vecs[7] = '{4'b0100, 4'b0100};
        for (int c = 0; c < 16; c++) exp33[c] = (c % 2 == 0) ? NR'(1 << ((c / 2) % NR)) : '0;

        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.req_last  = '0;
        bus.fifo_full = 1'b0;
        hold          = '0;

        // Reset state with every requester offering
        RST = 1'b1;
        for (int i = 0; i < NR; i++) offer(i, 8'(8'hE0 + i), 1'b1);
        repeat (3) @(posedge CLK);
        tick();
        chk("rst_grant", 32'(bus.grant), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_ready", 32'(bus.req_ready), 32'd0);
        chk("rst_wr_en", 32'(bus.fifo_wr_en), 32'd0);
        chk("rst_pkt_done", 32'(bus.pkt_done), 32'd0);

        // Two-byte packet from requester 1 while 2 also waits
        do_reset();
        offer(1, 8'h41, 1'b0);
        offer(1, 8'h54, 1'b1);
        offer(2, 8'h77, 1'b1);
        exp_byte(1, 8'h41, 1'b0);
        exp_byte(1, 8'h54, 1'b1);
        exp_byte(2, 8'h77, 1'b1);
        tick();
        chk("s32_idle_grant", 32'(bus.grant), 32'd0);
        tick();
        chk("s32_grant", 32'(bus.grant), 32'b0010);
        chk("s32_wr_en0", 32'(bus.fifo_wr_en), 32'd1);
        chk("s32_byte0", 32'(bus.fifo_data), 32'h41);
        tick();
        chk("s32_byte1", 32'(bus.fifo_data), 32'h54);
        chk("s32_done", 32'(bus.pkt_done), 32'd1);
        wait_drain("s32_drain", 20);

        // Table of arbitration vectors, priority chaining from row to row
        do_reset();
        for (int r = 0; r < 8; r++) begin
            int eidx;
            eidx = 0;
            for (int j = 0; j < NR; j++) if (vecs[r].exp_grant[j]) eidx = j;
            @(posedge CLK);
            #1;
            for (int i = 0; i < NR; i++) if (vecs[r].mask[i]) offer(i, 8'(r * 16 + i), 1'b1);
            exp_byte(eidx, 8'(r * 16 + eidx), 1'b1);
            wait_busy("vec_grant", 8, vecs[r].exp_grant);
            @(posedge CLK);
            #1;
            rq.delete();
            tick();
            chk("vec_drain", sb.size(), 0);
        end

        // All four with back-to-back 1-byte packets: 0,1,2,3,0 with one IDLE between
        do_reset();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < NR; i++) begin
                offer(i, 8'(8'hA0 + k * 4 + i), 1'b1);
                exp_byte(i, 8'(8'hA0 + k * 4 + i), 1'b1);
            end
        end
        tick();
        chk("s33_idle", 32'(bus.grant), 32'd0);
        for (int c = 0; c < 16; c++) begin
            tick();
            chk("s33_grant_seq", 32'(bus.grant), 32'(exp33[c]));
        end
        wait_drain("s33_drain", 10);

        // FIFO full for 5 cycles mid-packet
        do_reset();
        base = xfer_cnt;
        for (int b = 0; b < 6; b++) begin
            offer(0, 8'(8'hB0 + b), b == 5);
            exp_byte(0, 8'(8'hB0 + b), b == 5);
        end
        wait_xfers("s34_two_bytes", base + 2, 10);
        @(posedge CLK);
        #1;
        bus.fifo_full = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("s34_ready_stall", 32'(bus.req_ready), 32'd0);
            chk("s34_wr_stall", 32'(bus.fifo_wr_en), 32'd0);
            chk("s34_grant_held", 32'(bus.grant), 32'b0001);
        end
        @(posedge CLK);
        #1;
        bus.fifo_full = 1'b0;
        wait_drain("s34_drain", 20);
        chk("s34_count", xfer_cnt, base + 6);

        // Owner stalls mid-packet: grant held, waiting requester not served
        do_reset();
        for (int b = 0; b < 3; b++) begin
            offer(0, 8'(8'hC0 + b), b == 2);
            exp_byte(0, 8'(8'hC0 + b), b == 2);
        end
        offer(1, 8'hD0, 1'b1);
        exp_byte(1, 8'hD0, 1'b1);
        base = xfer_cnt;
        wait_xfers("s25_first", base + 1, 10);
        @(posedge CLK);
        #1;
        hold[0] = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            chk("s25_grant_held", 32'(bus.grant), 32'b0001);
            chk("s25_no_write", 32'(bus.fifo_wr_en), 32'd0);
            chk("s25_ready", 32'(bus.req_ready), 32'b0001);
        end
        @(posedge CLK);
        #1;
        hold[0] = 1'b0;
        wait_drain("s25_drain", 20);

        // Burst limit: 20-byte packet from 2, requester 3 interleaves after byte 16
        do_reset();
        for (int b = 1; b <= 20; b++) offer(2, 8'(b), b == 20);
        offer(3, 8'h33, 1'b1);
        for (int b = 1; b <= MB; b++) exp_byte(2, 8'(b), 1'b0);
        exp_byte(3, 8'h33, 1'b1);
        for (int b = MB + 1; b <= 20; b++) exp_byte(2, 8'(b), b == 20);
        wait_drain("s35_drain", 100);

        // Reset after 3 bytes of a packet aborts it
        do_reset();
        for (int b = 0; b < 8; b++) offer(1, 8'(8'h60 + b), b == 7);
        for (int b = 0; b < 3; b++) exp_byte(1, 8'(8'h60 + b), 1'b0);
        base = xfer_cnt;
        wait_xfers("s36_three", base + 3, 10);
        @(posedge CLK);
        #1;
        RST = 1'b1;
        tick();
        chk("s36_rst_wr_en", 32'(bus.fifo_wr_en), 32'd0);
        chk("s36_rst_ready", 32'(bus.req_ready), 32'd0);
        @(posedge CLK);
        #1;
        RST = 1'b0;
        rq.delete();
        sb.delete();
        tick();
        chk("s36_grant_clear", 32'(bus.grant), 32'd0);
        chk("s36_wr_clear", 32'(bus.fifo_wr_en), 32'd0);
        offer(0, 8'h90, 1'b1);
        offer(3, 8'h93, 1'b1);
        exp_byte(0, 8'h90, 1'b1);
        exp_byte(3, 8'h93, 1'b1);
        wait_busy("s36_regrant", 8, 4'b0001);
        wait_drain("s36_drain", 20);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
